// File: rtl/gpio_ctrl.sv
// gpio_ctrl: GPIO pins with OUT/DIR/SET/CLR registers, synchronised inputs, and optional edge interrupts (macro GPIO_CTRL_IRQ_EN).
// Ports: clk_i, rst_ni; bus write_i/data_be_i/addr_i/wdata_i/rdata_o; pins input_i/output_o/oe_o; irq_o.
module gpio_ctrl #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             write_i,
  input  logic [3:0]       data_be_i,
  input  logic [5:0]       addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  input  logic [WIDTH-1:0] input_i,
  output logic [WIDTH-1:0] output_o,
  output logic [WIDTH-1:0] oe_o,
  output logic             irq_o
);

  logic [3:0]       word;
  logic [31:0]      lane32;
  logic [WIDTH-1:0] lane;
  logic [WIDTH-1:0] wv;
  logic [WIDTH-1:0] in_q;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] rd_w;
  logic             sel_in, sel_out, sel_dir;
  logic             sel_set, sel_clr;
  logic             unused_bits;

`ifdef GPIO_CTRL_IRQ_EN
  logic             sel_ren, sel_fen;
  logic             sel_stat, sel_mask;
  logic [WIDTH-1:0] ren_q, ren_d;
  logic [WIDTH-1:0] fen_q, fen_d;
  logic [WIDTH-1:0] stat_q, stat_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] prev_q, ev;
  logic             irq_q, irq_d;
`endif

  assign word   = addr_i[5:2];
  assign lane32 = {{8{data_be_i[3]}},
                   {8{data_be_i[2]}},
                   {8{data_be_i[1]}},
                   {8{data_be_i[0]}}};
  assign lane   = lane32[WIDTH-1:0];
  assign wv     = wdata_i[WIDTH-1:0] & lane;

  assign unused_bits = ^{addr_i[1:0], wdata_i, lane32};

  assign sel_in  = (word == 4'd0);
  assign sel_out = (word == 4'd1);
  assign sel_dir = (word == 4'd2);
  assign sel_set = (word == 4'd3);
  assign sel_clr = (word == 4'd4);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= input_i;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign in_q = sync_q[SYNC_STAGES-1];

  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    if (write_i) begin
      unique case (1'b1)
        sel_out: out_d = (out_q & ~lane) | wv;
        sel_set: out_d = out_q | wv;
        sel_clr: out_d = out_q & ~wv;
        sel_dir: dir_d = (dir_q & ~lane) | wv;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= '0;
      dir_q <= '0;
    end else begin
      out_q <= out_d;
      dir_q <= dir_d;
    end
  end

  assign output_o = out_q;
  assign oe_o     = dir_q;

`ifdef GPIO_CTRL_IRQ_EN
  assign sel_ren  = (word == 4'd5);
  assign sel_fen  = (word == 4'd6);
  assign sel_stat = (word == 4'd7);
  assign sel_mask = (word == 4'd8);

  assign ev = (in_q & ~prev_q & ren_q)
            | (~in_q & prev_q & fen_q);
  assign irq_d = |(stat_q & mask_q);

  always_comb begin
    ren_d  = ren_q;
    fen_d  = fen_q;
    mask_d = mask_q;
    stat_d = stat_q;
    if (write_i) begin
      unique case (1'b1)
        sel_ren:  ren_d  = (ren_q & ~lane) | wv;
        sel_fen:  fen_d  = (fen_q & ~lane) | wv;
        sel_mask: mask_d = (mask_q & ~lane) | wv;
        sel_stat: stat_d = stat_q & ~wv;
        default: ;
      endcase
    end
    // OR-ing events after the clear lets a same-cycle set win
    stat_d = stat_d | ev;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ren_q  <= '0;
      fen_q  <= '0;
      stat_q <= '0;
      mask_q <= '0;
      prev_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ren_q  <= ren_d;
      fen_q  <= fen_d;
      stat_q <= stat_d;
      mask_q <= mask_d;
      prev_q <= in_q;
      irq_q  <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    rd_w = '0;
    unique case (1'b1)
      sel_in:   rd_w = in_q;
      sel_out:  rd_w = out_q;
      sel_dir:  rd_w = dir_q;
`ifdef GPIO_CTRL_IRQ_EN
      sel_ren:  rd_w = ren_q;
      sel_fen:  rd_w = fen_q;
      sel_stat: rd_w = stat_q;
      sel_mask: rd_w = mask_q;
`endif
      default: ;
    endcase
  end

  assign rdata_o = 32'(rd_w);

endmodule

// File: doc/gpio_ctrl.md
GPIO_CTRL -- requirements
Module: gpio_ctrl

Interface
REQ-001 Parameter WIDTH, default 16: number of GPIO pins, legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: input synchroniser depth, legal range 2..3.
REQ-003 Port clk_i, input, 1: single clock; all state on rising edge.
REQ-004 Port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-005 Port write_i, input, 1: bus write strobe, one cycle per write.
REQ-006 Port data_be_i, input, 4: byte enables for writes.
REQ-007 Port addr_i, input, 6: byte address; bits [1:0] ignored.
REQ-008 Port wdata_i, input, 32: write data.
REQ-009 Port rdata_o, output, 32: read data.
REQ-010 Port input_i, input, WIDTH: asynchronous pin inputs.
REQ-011 Port output_o, output, WIDTH: pin output values.
REQ-012 Port oe_o, output, WIDTH: per-pin output enable, 1 = drive.
REQ-013 Port irq_o, output, 1: level interrupt request.

Function
REQ-014 Register map (word offsets): 0x00 IN (RO), 0x04 OUT (RW), 0x08 DIR (RW), 0x0C SET (WO), 0x10 CLR (WO), 0x14 RISE_EN (RW), 0x18 FALL_EN (RW), 0x1C IRQ_STAT (RW1C), 0x20 IRQ_MASK (RW).
REQ-015 rdata_o is combinational from addr_i; bits at and above WIDTH read 0; WO and unmapped offsets read 0.
REQ-016 Writes take effect on the clk_i edge with write_i=1; each byte lane applies only where data_be_i is set; unmapped writes are ignored.
REQ-017 SET write: OUT |= wdata; CLR write: OUT &= ~wdata, both masked by byte lanes.
REQ-018 output_o = OUT and oe_o = DIR, both driven directly from registers.
REQ-019 input_i passes through a SYNC_STAGES-deep flop chain; IN = last stage. Latency from a pin change to IN is SYNC_STAGES cycles.
REQ-020 A previous-value flop holds IN delayed by one cycle. Rise event = IN & ~prev & RISE_EN; fall event = ~IN & prev & FALL_EN.
REQ-021 An event sets the matching IRQ_STAT bit on the next edge, one cycle after IN changes.
REQ-022 An IRQ_STAT bit is cleared by writing 1 to it; writing 0 has no effect.
REQ-023 If a set event and a W1C on the same bit occur in the same cycle, set wins.
REQ-024 irq_o = |(IRQ_STAT & IRQ_MASK), registered, with one cycle of latency after IRQ_STAT.
REQ-025 Events are evaluated for every pin regardless of DIR, so output pins looped back also generate events.

Reset
REQ-026 On rst_ni low, asynchronously: OUT, DIR, RISE_EN, FALL_EN, IRQ_STAT, IRQ_MASK, synchroniser chain and prev flop all go to 0.
REQ-027 During reset: output_o=0, oe_o=0, irq_o=0, and rdata_o reads 0 at every offset.
REQ-028 Reset deassertion produces no spurious edge events, because prev and IN both start at 0; a pin high at release yields one rise event only if RISE_EN is set.

Configuration
REQ-029 Macro GPIO_CTRL_IRQ_EN defined: REQ-020..REQ-025 are present.
REQ-030 Macro GPIO_CTRL_IRQ_EN undefined: offsets 0x14..0x20 read 0 and ignore writes, irq_o is tied to 0, and no edge logic is synthesised. REQ-014..REQ-019 are unchanged.

Verification
REQ-031 WIDTH=16: write DIR=0x00FF, then OUT=0xA5A5 with data_be_i=4'b0001 -> OUT=0x00A5, oe_o=0x00FF.
REQ-032 OUT=0x00F0, write SET=0x000F, then CLR=0x0030 -> output_o=0x00FF after SET and 0x00CF after CLR.
REQ-033 SYNC_STAGES=2: input_i[3] goes 0->1 at cycle N -> IN[3]=1 readable at N+2; with RISE_EN[3]=1 and IRQ_MASK[3]=1, IRQ_STAT[3]=1 at N+3 and irq_o=1 at N+4.
REQ-034 IRQ_STAT=0x0008: write 0x0008 to 0x1C in the same cycle as a new rise on pin 3 -> IRQ_STAT stays 0x0008; a W1C with no event -> 0x0000 and irq_o drops one cycle later.
REQ-035 Assert rst_ni mid-pattern with OUT=0xFFFF and irq_o=1 -> output_o, oe_o and irq_o are 0 immediately, without waiting for a clock edge.
REQ-036 Build without GPIO_CTRL_IRQ_EN, toggle pins and write 0xFFFF to 0x14..0x20 -> those offsets read 0 and irq_o stays 0.
